// File: rtl/alu_op_issue_if.sv
// Handshake bundle between decode, the ALU issue stage and the execute ALU.
//   in_*      : decode -> issue op fields with valid/ready
//   out_*     : issue -> execute op code, illegal flag and tag with valid/ready
// slave  = issue stage view, master = decode/execute (or bench) view.
interface alu_op_issue_if #(
  parameter int unsigned TAG_W         = 8,
  parameter int unsigned OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               alu_op;
  logic [2:0]               funct3;
  logic                     funct7_b5;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_illegal;
  logic [TAG_W-1:0]         out_tag;

  modport slave (
    input  in_valid, alu_op, funct3, funct7_b5, in_tag, out_ready,
    output in_ready, out_valid, Operation, out_illegal, out_tag
  );

  modport master (
    output in_valid, alu_op, funct3, funct7_b5, in_tag, out_ready,
    input  in_ready, out_valid, Operation, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_op_issue.sv
// ALU issue stage: decodes ALUOp/funct3/funct7_b5 into a 4-bit ALU op code and
// buffers it in a 2-entry skid buffer (main M drives outputs, skid S).
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous kill of all buffered ops
//   bus          : alu_op_issue_if.slave (input and output handshakes)
//   illegal_cnt  : saturating count of illegal ops delivered downstream
module alu_op_issue #(
  parameter int unsigned TAG_W         = 8,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_op_issue_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic                     ill;
    logic [TAG_W-1:0]         tag;
  } entry_t;

  state_t           state;
  entry_t           m_q;
  entry_t           s_q;
  entry_t           dec;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CODE_W-1:0] dec_code;
  logic             dec_ill;
  logic             accept;
  logic             drain;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  // Combinational decode of the incoming op; unsupported encodings map to 1111.
  always_comb begin
    dec_code = 4'b1111;
    dec_ill  = 1'b1;
    case (bus.alu_op)
      2'b00: begin
        dec_code = 4'b0010;
        dec_ill  = 1'b0;
      end
      2'b01: begin
        dec_ill = 1'b0;
        case (bus.funct3)
          3'b000:  dec_code = 4'b1000;
          3'b001:  dec_code = 4'b1010;
          3'b100:  dec_code = 4'b1100;
          3'b101:  dec_code = 4'b1001;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: begin
        // R-type (10) and I-type (11); only R-type honours funct7_b5 on funct3 000
        dec_ill = 1'b0;
        case (bus.funct3)
          3'b000:  dec_code = (bus.alu_op == 2'b10 && bus.funct7_b5) ? 4'b0110 : 4'b0010;
          3'b111:  dec_code = 4'b0000;
          3'b110:  dec_code = 4'b0001;
          3'b100:  dec_code = 4'b0011;
          3'b001:  dec_code = 4'b0100;
          3'b101:  dec_code = bus.funct7_b5 ? 4'b0111 : 4'b0101;
          3'b010:  dec_code = 4'b1100;
          default: dec_ill  = 1'b1;
        endcase
      end
    endcase
    dec.op  = OPCODE_LENGTH'(dec_code);
    dec.ill = dec_ill;
    dec.tag = bus.in_tag;
  end

  // Occupancy FSM, storage and illegal counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      // A drain in the flush cycle is still a delivery.
      if (drain && m_q.ill && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        state       <= EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              m_q         <= dec;
              out_valid_q <= 1'b1;
              state       <= ONE;
            end
          end
          ONE: begin
            if (accept && !drain) begin
              s_q        <= dec;
              in_ready_q <= 1'b0;
              state      <= FULL;
            end else if (accept && drain) begin
              m_q <= dec;
            end else if (drain) begin
              out_valid_q <= 1'b0;
              state       <= EMPTY;
            end
          end
          FULL: begin
            if (drain) begin
              m_q        <= s_q;
              in_ready_q <= 1'b1;
              state      <= ONE;
            end
          end
          default: begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.Operation   = m_q.op;
  assign bus.out_illegal = m_q.ill;
  assign bus.out_tag     = m_q.tag;
  assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode table streamed at full rate, then
// hand-written backpressure, reset, illegal-count and flush sequences.
module tb_alu_op_issue;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned NVEC   = 24;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] illegal_cnt;

  alu_op_issue_if #(.TAG_W(TAG_W), .OPCODE_LENGTH(OP_W)) bus ();

  alu_op_issue #(.TAG_W(TAG_W), .OPCODE_LENGTH(OP_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aop;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] exp_op;
    logic       exp_ill;
  } vec_t;

  vec_t vec [NVEC];
  int   checks;
  int   errors;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                        input logic [7:0] tag);
    bus.alu_op    = aop;
    bus.funct3    = f3;
    bus.funct7_b5 = f7;
    bus.in_tag    = tag;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;

    vec[0]  = '{2'b00, 3'b000, 1'b0, 4'b0010, 1'b0};
    vec[1]  = '{2'b00, 3'b111, 1'b1, 4'b0010, 1'b0};
    vec[2]  = '{2'b01, 3'b000, 1'b0, 4'b1000, 1'b0};
    vec[3]  = '{2'b01, 3'b001, 1'b0, 4'b1010, 1'b0};
    vec[4]  = '{2'b01, 3'b100, 1'b1, 4'b1100, 1'b0};
    vec[5]  = '{2'b01, 3'b101, 1'b0, 4'b1001, 1'b0};
    vec[6]  = '{2'b01, 3'b010, 1'b0, 4'b1111, 1'b1};
    vec[7]  = '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0};
    vec[8]  = '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b0};
    vec[9]  = '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0};
    vec[10] = '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0};
    vec[11] = '{2'b10, 3'b100, 1'b0, 4'b0011, 1'b0};
    vec[12] = '{2'b10, 3'b001, 1'b0, 4'b0100, 1'b0};
    vec[13] = '{2'b10, 3'b101, 1'b0, 4'b0101, 1'b0};
    vec[14] = '{2'b10, 3'b010, 1'b0, 4'b1100, 1'b0};
    vec[15] = '{2'b10, 3'b101, 1'b1, 4'b0111, 1'b0};
    vec[16] = '{2'b10, 3'b011, 1'b0, 4'b1111, 1'b1};
    vec[17] = '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0};
    vec[18] = '{2'b11, 3'b101, 1'b1, 4'b0111, 1'b0};
    vec[19] = '{2'b11, 3'b111, 1'b0, 4'b0000, 1'b0};
    vec[20] = '{2'b11, 3'b011, 1'b0, 4'b1111, 1'b1};
    vec[21] = '{2'b01, 3'b110, 1'b0, 4'b1111, 1'b1};
    vec[22] = '{2'b01, 3'b111, 1'b0, 4'b1111, 1'b1};
    vec[23] = '{2'b01, 3'b011, 1'b1, 4'b1111, 1'b1};

    // Reset state
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_op(2'b00, 3'b000, 1'b0, 8'h00);
    tick;
    tick;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_operation", 32'(bus.Operation), 32'h0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'h0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick;

    // Single SRA op: one-cycle latency
    bus.out_ready = 1'b1;
    set_op(2'b10, 3'b101, 1'b1, 8'h3C);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_op", 32'(bus.Operation), 32'b0111);
    chk("single_tag", 32'(bus.out_tag), 32'h3C);
    chk("single_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    chk("single_drained", 32'(bus.out_valid), 32'd0);

    // Decode table streamed back to back with out_ready high
    for (int i = 0; i < int'(NVEC); i++) begin
      set_op(vec[i].aop, vec[i].f3, vec[i].f7, 8'(8'h10 + i));
      bus.in_valid = 1'b1;
      tick;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_op", i), 32'(bus.Operation), 32'(vec[i].exp_op));
      chk($sformatf("vec%0d_ill", i), 32'(bus.out_illegal), 32'(vec[i].exp_ill));
      chk($sformatf("vec%0d_tag", i), 32'(bus.out_tag), 32'(8'h10 + i));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("vec%0d_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
      if (vec[i].exp_ill && exp_cnt < 3) exp_cnt++;
    end
    bus.in_valid = 1'b0;
    tick;
    chk("stream_drained", 32'(bus.out_valid), 32'd0);
    chk("stream_cnt_sat", 32'(illegal_cnt), 32'd3);

    // Backpressure: three stalled cycles with in_valid high
    bus.out_ready = 1'b0;
    set_op(2'b10, 3'b000, 1'b0, 8'hA1);
    bus.in_valid = 1'b1;
    tick;
    chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    set_op(2'b10, 3'b000, 1'b1, 8'hA2);
    tick;
    chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2_tag", 32'(bus.out_tag), 32'hA1);
    set_op(2'b10, 3'b111, 1'b0, 8'hA3);
    tick;
    chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3_valid", 32'(bus.out_valid), 32'd1);
    chk("bp3_tag", 32'(bus.out_tag), 32'hA1);
    chk("bp3_op", 32'(bus.Operation), 32'b0010);
    bus.out_ready = 1'b1;
    tick;
    chk("bp4_tag", 32'(bus.out_tag), 32'hA2);
    chk("bp4_op", 32'(bus.Operation), 32'b0110);
    chk("bp4_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    chk("bp5_tag", 32'(bus.out_tag), 32'hA3);
    chk("bp5_op", 32'(bus.Operation), 32'b0000);
    bus.in_valid = 1'b0;
    tick;
    chk("bp6_drained", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while holding an op
    set_op(2'b11, 3'b100, 1'b0, 8'h55);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("pre_rst_tag", 32'(bus.out_tag), 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_op", 32'(bus.Operation), 32'h0);
    chk("mid_rst_tag", 32'(bus.out_tag), 32'h0);
    chk("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    rst_n = 1'b1;
    tick;

    // Illegal branch counted on drain
    bus.out_ready = 1'b1;
    set_op(2'b01, 3'b110, 1'b0, 8'h77);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("brill_op", 32'(bus.Operation), 32'hF);
    chk("brill_ill", 32'(bus.out_illegal), 32'd1);
    chk("brill_cnt_pre", 32'(illegal_cnt), 32'd0);
    tick;
    chk("brill_cnt_post", 32'(illegal_cnt), 32'd1);
    chk("brill_drained", 32'(bus.out_valid), 32'd0);

    // Flush in FULL with in_valid high; illegal op drained in flush cycle counts
    bus.out_ready = 1'b0;
    set_op(2'b01, 3'b111, 1'b0, 8'hB1);
    bus.in_valid = 1'b1;
    tick;
    set_op(2'b10, 3'b100, 1'b0, 8'hB2);
    tick;
    chk("fl_full_in_ready", 32'(bus.in_ready), 32'd0);
    set_op(2'b10, 3'b001, 1'b0, 8'hB3);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_cnt", 32'(illegal_cnt), 32'd2);
    tick;
    chk("fl_no_capture", 32'(bus.out_valid), 32'd0);

    // Flush in ONE overrides a simultaneous accept
    bus.out_ready = 1'b0;
    set_op(2'b00, 3'b000, 1'b0, 8'hC1);
    bus.in_valid = 1'b1;
    tick;
    set_op(2'b10, 3'b110, 1'b0, 8'hC2);
    flush = 1'b1;
    tick;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl1_valid", 32'(bus.out_valid), 32'd0);
    chk("fl1_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    chk("fl1_no_capture", 32'(bus.out_valid), 32'd0);
    chk("fl1_cnt", 32'(illegal_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
